// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle MUL/DIVU/REMU sequencer borrowing the shared ALU (ports: clk, rst, start, op, opa, opb -> busy, done, result; alu_own/alu_a/alu_b/alu_sel out, alu_out in)
module alu_muldiv_seq #(
  parameter int WIDTH_DATA_LENGTH   = 32,
  parameter int WIDTH_ALUSEL_LENGTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [1:0]                     op,
  input  logic [WIDTH_DATA_LENGTH-1:0]   opa,
  input  logic [WIDTH_DATA_LENGTH-1:0]   opb,
  output logic                           busy,
  output logic                           done,
  output logic [WIDTH_DATA_LENGTH-1:0]   result,
  output logic                           alu_own,
  output logic [WIDTH_DATA_LENGTH-1:0]   alu_a,
  output logic [WIDTH_DATA_LENGTH-1:0]   alu_b,
  output logic [WIDTH_ALUSEL_LENGTH-1:0] alu_sel,
  input  logic [WIDTH_DATA_LENGTH-1:0]   alu_out
);
  localparam int W  = WIDTH_DATA_LENGTH;
  localparam int SW = WIDTH_ALUSEL_LENGTH;
  localparam int CW = $clog2(W);
  localparam logic [SW-1:0] SEL_ADD  = SW'(4'b0000);
  localparam logic [SW-1:0] SEL_SUB  = SW'(4'b0001);
  localparam logic [SW-1:0] SEL_SLTU = SW'(4'b0100);
  localparam logic [SW-1:0] SEL_A    = SW'(4'b1110);
  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DCMP, S_DSUB, S_DONE} state_t;
  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lt_q, lt_d;
  logic [W-1:0]  acc_q, acc_d, mc_q, mc_d, mp_q, mp_d;
  logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  rs, quo_bit;
  logic          last;
  assign rs      = {rem_q[W-2:0], quo_q[W-1]};
  assign quo_bit = {quo_q[W-1:1], ~lt_q};
  assign last    = cnt_q == CW'(W - 1);
  assign busy    = state_q != S_IDLE;
  assign done    = state_q == S_DONE;
  assign result  = res_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      acc_q   <= '0;
      mc_q    <= '0;
      mp_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      res_q   <= res_d;
    end
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    res_d   = res_q;
    alu_own = 1'b0;
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = SEL_ADD;
    case (state_q)
      S_IDLE: if (start) begin
        op_d  = op;
        cnt_d = '0;
        case (op)
          2'b00: begin
            acc_d   = '0;
            mc_d    = opa;
            mp_d    = opb;
            state_d = S_MUL;
          end
          2'b01, 2'b10: begin
            rem_d   = '0;
            quo_d   = opa;
            div_d   = opb;
            res_d   = op == 2'b01 ? '1 : opa;
            state_d = opb == '0 ? S_DONE : S_DCMP;
          end
          default: begin
            res_d   = '0;
            state_d = S_DONE;
          end
        endcase
      end
      S_MUL: begin
        alu_own = 1'b1;
        alu_a   = acc_q;
        alu_b   = mc_q;
        alu_sel = mp_q[0] ? SEL_ADD : SEL_A;
        acc_d   = alu_out;
        mc_d    = mc_q << 1;
        mp_d    = mp_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        res_d   = last ? alu_out : res_q;
        state_d = last ? S_DONE : S_MUL;
      end
      S_DCMP: begin
        alu_own = 1'b1;
        alu_a   = rs;
        alu_b   = div_q;
        alu_sel = SEL_SLTU;
        rem_d   = rs;
        lt_d    = alu_out[0];
        quo_d   = quo_q << 1;
        state_d = S_DSUB;
      end
      S_DSUB: begin
        alu_own = 1'b1;
        alu_a   = rem_q;
        alu_b   = div_q;
        alu_sel = lt_q ? SEL_A : SEL_SUB;
        rem_d   = alu_out;
        quo_d   = quo_bit;
        cnt_d   = cnt_q + 1'b1;
        res_d   = last ? (op_q == 2'b01 ? quo_bit : alu_out) : res_q;
        state_d = last ? S_DONE : S_DCMP;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed self-checking bench for alu_muldiv_seq with a behavioural shared ALU
module tb_alu_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] opa = '0, opb = '0;
  logic        busy, done, alu_own;
  logic [31:0] result, alu_a, alu_b, alu_out;
  logic [3:0]  alu_sel;
  int checks = 0;
  int failures = 0;

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .alu_own(alu_own),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    case (alu_sel)
      4'b0000: alu_out = alu_a + alu_b;
      4'b0001: alu_out = alu_a - alu_b;
      4'b0100: alu_out = {31'b0, alu_a < alu_b};
      4'b1110: alu_out = alu_a;
      default: alu_out = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, then advance until done (bounded); optionally pulse a
  // second start with other operands at cycle inj. Returns in IDLE after done.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int inj, output int cyc, output int own, output logic [31:0] res);
    op = o; opa = a; opb = b; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    own = 0;
    while (!done && cyc < 100) begin
      own += int'(alu_own);
      if (cyc == inj) begin
        start = 1'b1; op = 2'b00; opa = 32'd9; opb = 32'd9;
      end else start = 1'b0;
      step();
      cyc++;
    end
    start = 1'b0;
    res = result;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || alu_own !== 1'b0 || result !== 32'd0 ||
        alu_a !== 32'd0 || alu_b !== 32'd0 || alu_sel !== 4'd0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b own=%b result=%h a=%h b=%h sel=%h, want all 0",
               busy, done, alu_own, result, alu_a, alu_b, alu_sel);
    end
    rst = 1'b0;
  endtask

  task automatic test_mul();
    int cyc, own;
    logic [31:0] res;
    do_op(2'b00, 32'd7, 32'd6, -1, cyc, own, res);
    checks++;
    if (res !== 32'd42) begin failures++; $display("FAIL mul_7x6 result: got %0d want 42", res); end
    checks++;
    if (cyc !== 33) begin failures++; $display("FAIL mul_7x6 latency: got %0d want 33", cyc); end
    checks++;
    if (own !== 32) begin failures++; $display("FAIL mul_7x6 alu_own cycles: got %0d want 32", own); end
    checks++;
    if (result !== 32'd42 || busy !== 1'b0 || alu_sel !== 4'd0) begin
      failures++;
      $display("FAIL mul_hold: result=%0d busy=%b sel=%h want 42/0/0", result, busy, alu_sel);
    end
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, cyc, own, res);
    checks++;
    if (res !== 32'h00000001) begin failures++; $display("FAIL mul_wrap: got %h want 00000001", res); end
  endtask

  task automatic test_div();
    int cyc, own;
    logic [31:0] res;
    do_op(2'b01, 32'd100, 32'd7, -1, cyc, own, res);
    checks++;
    if (res !== 32'd14) begin failures++; $display("FAIL divu_100_7: got %0d want 14", res); end
    checks++;
    if (cyc !== 65) begin failures++; $display("FAIL divu latency: got %0d want 65", cyc); end
    checks++;
    if (own !== 64) begin failures++; $display("FAIL divu alu_own cycles: got %0d want 64", own); end
    do_op(2'b10, 32'd100, 32'd7, -1, cyc, own, res);
    checks++;
    if (res !== 32'd2) begin failures++; $display("FAIL remu_100_7: got %0d want 2", res); end
    do_op(2'b01, 32'hFFFFFFFF, 32'd1, -1, cyc, own, res);
    checks++;
    if (res !== 32'hFFFFFFFF) begin failures++; $display("FAIL divu_max_1: got %h want ffffffff", res); end
    do_op(2'b10, 32'd1000, 32'd33, -1, cyc, own, res);
    checks++;
    if (res !== 32'd10) begin failures++; $display("FAIL remu_1000_33: got %0d want 10", res); end
  endtask

  task automatic test_div_zero();
    int cyc, own;
    logic [31:0] res;
    do_op(2'b01, 32'd55, 32'd0, -1, cyc, own, res);
    checks++;
    if (res !== 32'hFFFFFFFF || cyc !== 1 || own !== 0) begin
      failures++;
      $display("FAIL divu_by_0: res=%h cyc=%0d own=%0d want ffffffff/1/0", res, cyc, own);
    end
    do_op(2'b10, 32'd123, 32'd0, -1, cyc, own, res);
    checks++;
    if (res !== 32'd123 || cyc !== 1 || own !== 0) begin
      failures++;
      $display("FAIL remu_by_0: res=%0d cyc=%0d own=%0d want 123/1/0", res, cyc, own);
    end
    do_op(2'b11, 32'd5, 32'd6, -1, cyc, own, res);
    checks++;
    if (res !== 32'd0 || cyc !== 1 || own !== 0) begin
      failures++;
      $display("FAIL op_reserved: res=%0d cyc=%0d own=%0d want 0/1/0", res, cyc, own);
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, own;
    logic [31:0] res;
    do_op(2'b00, 32'd7, 32'd6, 10, cyc, own, res);
    checks++;
    if (res !== 32'd42 || cyc !== 33) begin
      failures++;
      $display("FAIL start_while_busy: res=%0d cyc=%0d want 42/33", res, cyc);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_not_queued: busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    op = 2'b01; opa = 32'd8; opb = 32'd0; start = 1'b1;
    step();
    op = 2'b00; opa = 32'd3; opb = 32'd5;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL done_cycle: done=%b busy=%b want 1/1", done, busy);
    end
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done_ignored: busy=%b done=%b want 0/0", busy, done);
    end
    step();
  endtask

  task automatic test_reset_mid_op();
    int cyc, own;
    logic [31:0] res;
    op = 2'b01; opa = 32'd100; opb = 32'd7; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    while (cyc < 20) begin step(); cyc++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 32'd0 || alu_own !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_divu: busy=%b result=%h own=%b done=%b want 0/0/0/0",
               busy, result, alu_own, done);
    end
    do_op(2'b00, 32'd3, 32'd5, -1, cyc, own, res);
    checks++;
    if (res !== 32'd15 || cyc !== 33) begin
      failures++;
      $display("FAIL mul_after_reset: res=%0d cyc=%0d want 15/33", res, cyc);
    end
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
